// File: rtl/exp_unit_pipe_pkg.sv
// rtl/exp_unit_pipe_pkg.sv - shared mode encodings and bias helper for the exponent unit
package exp_unit_pipe_pkg;

    typedef enum logic [1:0] {
        EXP_ADD   = 2'b00,
        EXP_SUB   = 2'b01,
        EXP_MBIAS = 2'b10,
        EXP_DBIAS = 2'b11
    } exp_mode_e;

    // IEEE-style bias for an exponent field of width ew
    function automatic int default_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

endpackage

// File: rtl/exp_pipe_slice.sv
// rtl/exp_pipe_slice.sv - one valid/ready register slice with async active-low clear
module exp_pipe_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid;
    logic [W-1:0] data;

    // Slice can take a new item when empty or when its item leaves this cycle
    assign in_ready  = ~valid | out_ready;
    assign out_valid = valid;
    assign out_data  = data;

    // Hold the item until downstream takes it; reset drops anything in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (in_ready) begin
            valid <= in_valid;
            if (in_valid) begin
                data <= in_data;
            end
        end
    end

endmodule

// File: rtl/exp_unit_pipe.sv
// rtl/exp_unit_pipe.sv - two-stage exponent add/sub/bias unit with valid/ready streaming
module exp_unit_pipe
    import exp_unit_pipe_pkg::*;
#(
    parameter int EW   = 8,
    parameter int BIAS = default_bias(EW),
    parameter bit SAT  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [EW-1:0] Oper0_A_i,
    input  logic [EW-1:0] Oper0_B_i,
    input  logic [EW-1:0] Oper1_A_i,
    input  logic [EW-1:0] Oper1_B_i,
    input  logic          sel_A_i,
    input  logic          sel_B_i,
    input  logic [1:0]    mode_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [EW-1:0] Data_Result_o,
    output logic          Overflow_flag_o,
    output logic          Underflow_flag_o,
    output logic          Zero_flag_o
);

    localparam int S1W = EW + 4;
    localparam int S2W = EW + 3;
    localparam logic [EW+1:0] BIAS_W = (EW+2)'(BIAS);
    localparam logic [EW+1:0] MAX_W  = (EW+2)'((1 << EW) - 1);
    localparam logic [EW+1:0] ZERO_W = '0;

    logic [EW-1:0]  a_op, b_op;
    logic [EW+1:0]  r1;
    logic [S1W-1:0] s1_din, s1_dout;
    logic           s1_valid, s2_ready;

    logic [EW+1:0]  r1_q, r2;
    logic [1:0]     mode_q;
    logic [EW-1:0]  res;
    logic           ovf, unf;
    logic [S2W-1:0] s2_din, s2_dout;

    // Stage 1: pick operands and form the zero-extended sum or difference
    always_comb begin
        a_op = sel_A_i ? Oper1_A_i : Oper0_A_i;
        b_op = sel_B_i ? Oper1_B_i : Oper0_B_i;
        if (mode_i == EXP_SUB || mode_i == EXP_DBIAS) begin
            r1 = {2'b00, a_op} - {2'b00, b_op};
        end else begin
            r1 = {2'b00, a_op} + {2'b00, b_op};
        end
        s1_din = {r1, mode_i};
    end

    exp_pipe_slice #(.W(S1W)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_i),
        .in_ready  (in_ready_o),
        .in_data   (s1_din),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_dout)
    );

    assign {r1_q, mode_q} = s1_dout;

    // Stage 2: apply bias for mult/div, then derive range flags and final result
    always_comb begin
        r2  = r1_q;
        ovf = 1'b0;
        unf = 1'b0;
        res = r1_q[EW-1:0];
        if (mode_q == EXP_MBIAS || mode_q == EXP_DBIAS) begin
            r2  = (mode_q == EXP_DBIAS) ? (r1_q + BIAS_W) : (r1_q - BIAS_W);
            ovf = $signed(r2) >= $signed(MAX_W);
            unf = $signed(r2) <= $signed(ZERO_W);
            res = r2[EW-1:0];
            if (SAT && ovf) begin
                res = '1;
            end else if (SAT && unf) begin
                res = '0;
            end
        end else begin
            // Plain add/sub: carry out is overflow, a negative difference is a borrow
            ovf = r2[EW] & ~r2[EW+1];
            unf = r2[EW+1];
            res = r2[EW-1:0];
        end
        s2_din = {res, ovf, unf, (res == '0)};
    end

    exp_pipe_slice #(.W(S2W)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_din),
        .out_valid (out_valid_o),
        .out_ready (out_ready_i),
        .out_data  (s2_dout)
    );

    assign {Data_Result_o, Overflow_flag_o, Underflow_flag_o, Zero_flag_o} = s2_dout;

endmodule

// File: tb/tb_exp_unit_pipe.sv
// tb/tb_exp_unit_pipe.sv - self-checking bench for exp_unit_pipe (EW=8, BIAS=127, SAT=1)
module tb_exp_unit_pipe;

    typedef struct packed {
        logic [1:0] mode;
        logic       sa;
        logic       sb;
        logic [7:0] o0a;
        logic [7:0] o0b;
        logic [7:0] o1a;
        logic [7:0] o1b;
    } op_t;

    typedef struct packed {
        logic [7:0] res;
        logic       ovf;
        logic       unf;
        logic       zero;
    } res_t;

    typedef struct {
        op_t  op;
        res_t exp;
    } vec_t;

    typedef struct {
        res_t r;
        int   acc;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] Oper0_A_i, Oper0_B_i, Oper1_A_i, Oper1_B_i;
    logic       sel_A_i, sel_B_i;
    logic [1:0] mode_i;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [7:0] Data_Result_o;
    logic       Overflow_flag_o, Underflow_flag_o, Zero_flag_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   chk_lat = 1'b0;
    logic last_in_ready;
    sb_t  q[$];
    int   deliv_cyc[$];
    vec_t vecs[$];

    exp_unit_pipe #(.EW(8), .BIAS(127), .SAT(1'b1)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .Oper0_A_i        (Oper0_A_i),
        .Oper0_B_i        (Oper0_B_i),
        .Oper1_A_i        (Oper1_A_i),
        .Oper1_B_i        (Oper1_B_i),
        .sel_A_i          (sel_A_i),
        .sel_B_i          (sel_B_i),
        .mode_i           (mode_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .Data_Result_o    (Data_Result_o),
        .Overflow_flag_o  (Overflow_flag_o),
        .Underflow_flag_o (Underflow_flag_o),
        .Zero_flag_o      (Zero_flag_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Exponent arithmetic straight from the mode definitions, using plain integers
    function automatic res_t model(input op_t o);
        res_t r;
        int a, b, s;
        a = o.sa ? int'(o.o1a) : int'(o.o0a);
        b = o.sb ? int'(o.o1b) : int'(o.o0b);
        r = '0;
        case (o.mode)
            2'd0: begin s = a + b; r.ovf = (s > 255); r.res = 8'(s); end
            2'd1: begin s = a - b; r.unf = (s < 0);   r.res = 8'(s); end
            default: begin
                s = (o.mode == 2'd2) ? (a + b - 127) : (a - b + 127);
                if (s >= 255) begin r.ovf = 1'b1; r.res = 8'd255; end
                else if (s <= 0) begin r.unf = 1'b1; r.res = 8'd0; end
                else r.res = 8'(s);
            end
        endcase
        r.zero = (r.res == 8'd0);
        return r;
    endfunction

    function automatic vec_t mk(input int m, input int sa, input int sb, input int a0, input int b0,
                                input int a1, input int b1, input int res, input int ovf,
                                input int unf, input int zero);
        vec_t v;
        v.op  = {2'(m), 1'(sa), 1'(sb), 8'(a0), 8'(b0), 8'(a1), 8'(b1)};
        v.exp = {8'(res), 1'(ovf), 1'(unf), 1'(zero)};
        return v;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        return o;
    endfunction

    // One clock: drive at negedge, sample 1 time unit later, score outputs and accepts
    task automatic cycle(input op_t o, input logic v, input logic ordy, input bit use_tab,
                         input res_t tab);
        sb_t  e;
        res_t got;
        @(negedge clk);
        {mode_i, sel_A_i, sel_B_i, Oper0_A_i, Oper0_B_i, Oper1_A_i, Oper1_B_i} = o;
        in_valid_i  = v;
        out_ready_i = ordy;
        #1;
        last_in_ready = in_ready_o;
        if (out_valid_o) begin
            got = {Data_Result_o, Overflow_flag_o, Underflow_flag_o, Zero_flag_o};
            if (q.size() == 0) begin
                chk(1'b0, "spurious_out", $sformatf("got res=%0d with nothing outstanding", got.res));
            end else begin
                chk(got == q[0].r, "result",
                    $sformatf("cyc %0d got res=%0d ovf/unf/zero=%b%b%b required res=%0d ovf/unf/zero=%b%b%b",
                              cyc, got.res, got.ovf, got.unf, got.zero,
                              q[0].r.res, q[0].r.ovf, q[0].r.unf, q[0].r.zero));
                if (chk_lat)
                    chk(cyc - q[0].acc == 2, "latency",
                        $sformatf("got %0d cycles required 2", cyc - q[0].acc));
                if (ordy) begin
                    void'(q.pop_front());
                    deliv_cyc.push_back(cyc);
                end
            end
        end
        if (v && in_ready_o) begin
            e.r   = use_tab ? tab : model(o);
            e.acc = cyc;
            q.push_back(e);
        end
        cyc++;
    endtask

    initial begin
        op_t items[4];
        int  k;

        rst = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        {mode_i, sel_A_i, sel_B_i, Oper0_A_i, Oper0_B_i, Oper1_A_i, Oper1_B_i} = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk({out_valid_o, Data_Result_o, Overflow_flag_o, Underflow_flag_o, Zero_flag_o} == '0,
            "reset_outputs", $sformatf("got valid=%b res=%0d flags=%b%b%b required all 0",
                                       out_valid_o, Data_Result_o, Overflow_flag_o,
                                       Underflow_flag_o, Zero_flag_o));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk(in_ready_o == 1'b1, "ready_after_reset", $sformatf("got %b required 1", in_ready_o));

        // Directed vectors, streamed back to back with a free consumer
        vecs.push_back(mk(0, 0, 0, 100,  27,  3,  4, 127, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 200, 200,  0,  0, 255, 1, 0, 0));
        vecs.push_back(mk(3, 0, 0, 130,   3,  0,  0, 254, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0,  10,  20,  0,  0,   0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 200,  56,  0,  0,   0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0,   5,   9,  0,  0, 252, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1,   1,   2, 40, 60, 100, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0,   9,  50, 70, 99,  20, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 254, 127,  0,  0, 254, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 255, 127,  0,  0, 255, 1, 0, 0));
        vecs.push_back(mk(2, 0, 0, 127,   1,  0,  0,   1, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 127,   0,  0,  0,   0, 0, 1, 1));
        vecs.push_back(mk(3, 0, 0,   0, 127,  0,  0,   0, 0, 1, 1));
        vecs.push_back(mk(3, 0, 0, 255,   0,  0,  0, 255, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0,  77,  77,  0,  0,   0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 255,   1,  0,  0,   0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 128, 127,  0,  0, 255, 0, 0, 0));

        chk_lat = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].op, 1'b1, 1'b1, 1'b1, vecs[i].exp);
        end
        for (int i = 0; i < 4; i++) cycle('0, 1'b0, 1'b1, 1'b0, '0);
        chk(q.size() == 0, "table_drained", $sformatf("got %0d outstanding required 0", q.size()));
        chk_lat = 1'b0;

        // Back-to-back items against a stalled consumer, then release
        for (int i = 0; i < 4; i++) items[i] = rand_op();
        deliv_cyc.delete();
        k = 0;
        for (int c = 0; c < 5; c++) begin
            cycle(items[k], 1'b1, 1'b0, 1'b0, '0);
            chk(last_in_ready == (c < 2), "stall_in_ready",
                $sformatf("cycle %0d got %b required %b", c, last_in_ready, (c < 2)));
            if (last_in_ready) k++;
        end
        for (int c = 0; c < 20 && (k < 4 || q.size() != 0); c++) begin
            cycle(items[k % 4], (k < 4), 1'b1, 1'b0, '0);
            if (k < 4 && last_in_ready) k++;
        end
        chk(deliv_cyc.size() == 4, "stall_count",
            $sformatf("got %0d deliveries required 4", deliv_cyc.size()));
        if (deliv_cyc.size() == 4)
            chk(deliv_cyc[3] - deliv_cyc[0] == 3, "stall_throughput",
                $sformatf("got span %0d cycles required 3", deliv_cyc[3] - deliv_cyc[0]));

        // Randomized streaming with random back-pressure
        for (int i = 0; i < 600; i++) begin
            cycle(rand_op(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 1'b0, '0);
        end
        for (int i = 0; i < 6; i++) cycle('0, 1'b0, 1'b1, 1'b0, '0);
        chk(q.size() == 0, "random_drained", $sformatf("got %0d outstanding required 0", q.size()));

        // Asynchronous reset with two items in flight
        cycle(rand_op(), 1'b1, 1'b0, 1'b0, '0);
        cycle(rand_op(), 1'b1, 1'b0, 1'b0, '0);
        @(negedge clk);
        in_valid_i = 1'b0;
        @(posedge clk);
        #3;
        chk(out_valid_o == 1'b1, "inflight_before_reset", $sformatf("got %b required 1", out_valid_o));
        rst = 1'b0;
        #1;
        chk({out_valid_o, Data_Result_o, Overflow_flag_o, Underflow_flag_o, Zero_flag_o} == '0,
            "async_reset_outputs", $sformatf("got valid=%b res=%0d flags=%b%b%b required all 0",
                                             out_valid_o, Data_Result_o, Overflow_flag_o,
                                             Underflow_flag_o, Zero_flag_o));
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) cycle('0, 1'b0, 1'b1, 1'b0, '0);
        chk(last_in_ready == 1'b1, "ready_after_midreset", $sformatf("got %b required 1", last_in_ready));

        // One fresh item after the mid-run reset still comes through cleanly
        chk_lat = 1'b1;
        cycle(vecs[0].op, 1'b1, 1'b1, 1'b1, vecs[0].exp);
        for (int i = 0; i < 3; i++) cycle('0, 1'b0, 1'b1, 1'b0, '0);
        chk(q.size() == 0, "post_reset_item", $sformatf("got %0d outstanding required 0", q.size()));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
